// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM read port and
// hands {ce, pc} to ID so it lines up with the SRAM data one edge later.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          STALL_WD = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_WD-1:0] stall,
    input  logic [32:0]         br_bus,
    output logic [32:0]         if_to_id_bus,
    output logic                inst_sram_en,
    output logic [3:0]          inst_sram_wen,
    output logic [31:0]         inst_sram_addr,
    output logic [31:0]         inst_sram_wdata,
    output logic                fetch_adel,
    output logic [31:0]         fetch_cnt
);
    localparam logic STOP = 1'b1;

    logic        br_e;
    logic [31:0] br_addr;
    logic [31:0] pc_q, pc_d, next_pc;
    logic        ce_q, ce_d;
    logic        pend_v_q, pend_v_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic [31:0] cnt_q, cnt_d;

    assign {br_e, br_addr} = br_bus;

    // A live branch beats a remembered one; otherwise fall through sequentially.
    assign next_pc = br_e     ? br_addr     :
                     pend_v_q ? pend_addr_q :
                                pc_q + 32'd4;

    always_comb begin
        pc_d        = pc_q;
        ce_d        = ce_q;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        if (!ce_q) begin
            ce_d = 1'b1;
            pc_d = RESET_PC;
        end else if (stall[0] != STOP) begin
            pc_d     = next_pc;
            pend_v_d = 1'b0;
        end else if (br_e) begin
            pend_v_d    = 1'b1;
            pend_addr_d = br_addr;
        end
    end

    assign cnt_d = inst_sram_en ? cnt_q + 32'd1 : cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q        <= RESET_PC - 32'd4;
            ce_q        <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_addr_q <= 32'd0;
            cnt_q       <= 32'd0;
        end else begin
            pc_q        <= pc_d;
            ce_q        <= ce_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            cnt_q       <= cnt_d;
        end
    end

    // SRAM enable drops during an IF/ID stall so ID keeps seeing the same data.
    assign if_to_id_bus    = {ce_q, pc_q};
    assign inst_sram_addr  = pc_q;
    assign fetch_adel      = ce_q & (pc_q[1:0] != 2'b00);
    assign inst_sram_en    = ce_q & ~fetch_adel & (stall[1] != STOP);
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'd0;
    assign fetch_cnt       = cnt_q;
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: reset, sequential fetch, branch, stalled redirects,
// misaligned targets, PC wrap and reset in mid-operation.
module tb_if_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        fetch_adel;
    logic [31:0] fetch_cnt;

    int checks   = 0;
    int failures = 0;

    if_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .br_bus          (br_bus),
        .if_to_id_bus    (if_to_id_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .fetch_adel      (fetch_adel),
        .fetch_cnt       (fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic br(input logic e, input logic [31:0] a);
        br_bus = {e, a};
    endtask

    initial begin
        rst = 1'b0; stall = 6'b0; br(1'b0, 32'h0);
        repeat (3) step();
        chk("rst_bus", 64'(if_to_id_bus), 64'({1'b0, 32'hBFBF_FFFC}));
        chk("rst_en", 64'(inst_sram_en), 64'd0);
        chk("rst_cnt", 64'(fetch_cnt), 64'd0);
        chk("rst_wen", 64'({inst_sram_wen, inst_sram_wdata}), 64'd0);

        rst = 1'b1;
        step();
        chk("c1_bus", 64'(if_to_id_bus), 64'({1'b1, 32'hBFC0_0000}));
        chk("c1_en", 64'(inst_sram_en), 64'd1);
        step();
        chk("c2_pc", 64'(inst_sram_addr), 64'hBFC0_0004);
        step();
        chk("c3_cnt", 64'(fetch_cnt), 64'd2);
        step(); step();
        chk("pc10", 64'(inst_sram_addr), 64'hBFC0_0010);

        br(1'b1, 32'hBFC0_0100);
        step();
        br(1'b0, 32'h0);
        chk("br_pc", 64'(inst_sram_addr), 64'hBFC0_0100);
        step();
        chk("br_pc4", 64'(inst_sram_addr), 64'hBFC0_0104);
        chk("br_cnt", 64'(fetch_cnt), 64'd6);

        // IF/ID + PC stall, redirect seen only in the first stalled cycle
        stall = 6'b000011; br(1'b1, 32'hBFC0_0200);
        step();
        br(1'b0, 32'h0);
        chk("st1_pc", 64'(inst_sram_addr), 64'hBFC0_0104);
        chk("st1_en", 64'(inst_sram_en), 64'd0);
        step();
        chk("st2_pc", 64'(inst_sram_addr), 64'hBFC0_0104);
        step();
        chk("st3_en", 64'(inst_sram_en), 64'd0);
        chk("st3_cnt", 64'(fetch_cnt), 64'd6);
        stall = 6'b0;
        step();
        chk("pend_pc", 64'(inst_sram_addr), 64'hBFC0_0200);
        chk("pend_cnt", 64'(fetch_cnt), 64'd7);
        step();
        chk("pend_clr", 64'(inst_sram_addr), 64'hBFC0_0204);

        // newer stalled redirect overwrites the pending one
        stall = 6'b000001; br(1'b1, 32'h200);
        step();
        br(1'b1, 32'h300);
        step();
        chk("ovw_hold", 64'(inst_sram_addr), 64'hBFC0_0204);
        stall = 6'b0; br(1'b0, 32'h0);
        step();
        chk("ovw_pc", 64'(inst_sram_addr), 64'h300);
        chk("ovw_cnt", 64'(fetch_cnt), 64'd11);

        // live branch beats pending
        stall = 6'b000001; br(1'b1, 32'h500);
        step();
        stall = 6'b0; br(1'b1, 32'h400);
        step();
        br(1'b0, 32'h0);
        chk("live_pc", 64'(inst_sram_addr), 64'h400);
        step();
        chk("live_pc4", 64'(inst_sram_addr), 64'h404);
        chk("live_cnt", 64'(fetch_cnt), 64'd14);

        // misaligned target
        br(1'b1, 32'hBFC0_0102);
        step();
        br(1'b0, 32'h0);
        chk("mis_adel", 64'(fetch_adel), 64'd1);
        chk("mis_en", 64'(inst_sram_en), 64'd0);
        chk("mis_bus", 64'(if_to_id_bus), 64'({1'b1, 32'hBFC0_0102}));
        step();
        chk("mis_cnt", 64'(fetch_cnt), 64'd15);

        // 32-bit wrap of the sequential PC
        br(1'b1, 32'hFFFF_FFFC);
        step();
        br(1'b0, 32'h0);
        chk("wrap_adel", 64'(fetch_adel), 64'd0);
        step();
        chk("wrap_pc", 64'(inst_sram_addr), 64'h0);
        chk("wrap_cnt", 64'(fetch_cnt), 64'd16);

        // reset with a pending redirect and PC stall
        stall = 6'b000001; br(1'b1, 32'h700);
        step();
        br(1'b0, 32'h0); rst = 1'b0;
        step();
        chk("mrst_bus", 64'(if_to_id_bus), 64'({1'b0, 32'hBFBF_FFFC}));
        chk("mrst_cnt", 64'(fetch_cnt), 64'd0);
        rst = 1'b1; stall = 6'b0;
        step();
        chk("mrst_pc", 64'(if_to_id_bus), 64'({1'b1, 32'hBFC0_0000}));
        step();
        chk("mrst_lost", 64'(inst_sram_addr), 64'hBFC0_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch (IF) stage of the 5-stage MIPS pipeline; the sending end of the IF→ID interface.
- Owns the PC register and drives the synchronous instruction SRAM port.
- Emits `{ce, pc}` on `if_to_id_bus`, timed so that ID registers it on the same edge the SRAM data for that PC appears on `inst_sram_rdata`.
- Consumes `br_bus` from ID and redirects fetch. Redirects that arrive while the PC is stalled are remembered, not dropped.

Parameters:
- RESET_PC, 32'hBFC0_0000, address of the first fetched instruction after reset.
- STALL_WD, 6, width of the `stall` bus (`StallBus`).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (reset when rst==0 at posedge clk).
- stall  in  STALL_WD  pipeline stall vector; bit0 = PC stop, bit1 = IF/ID stop; 1 = `Stop`.
- br_bus  in  33  {br_e, br_addr[31:0]} from ID, combinational in ID's cycle.
- if_to_id_bus  out  33  {ce, pc[31:0]} to ID.
- inst_sram_en  out  1  SRAM read enable.
- inst_sram_wen  out  4  always 4'b0000.
- inst_sram_addr  out  32  fetch address.
- inst_sram_wdata  out  32  always 32'b0.
- fetch_adel  out  1  current PC is not word-aligned (address-error-on-fetch flag, for later exception logic).
- fetch_cnt  out  32  number of SRAM fetches issued since reset (debug/perf).

Behaviour:
- State registers: pc_r[31:0], ce_r, pend_v, pend_addr[31:0], fetch_cnt.
- Reset (rst==0 at edge):
  - pc_r ← RESET_PC−4; ce_r ← 0; pend_v ← 0; pend_addr ← 0; fetch_cnt ← 0.
  - Reset overrides all other inputs, including reset asserted mid-stall or with br_e high.
- Outputs while ce_r==0: if_to_id_bus = {0, RESET_PC−4}; inst_sram_en = 0.
- First cycle after reset release: next edge loads ce_r ← 1, pc_r ← RESET_PC, regardless of stall.
- next_pc priority:
  - br_e ? br_addr
  - : pend_v ? pend_addr
  - : pc_r + 4, where pc_r + 4 is 32-bit wrap-around (32'hFFFF_FFFC + 4 = 0).
- Edge update when ce_r==1 and stall[0]==NoStop: pc_r ← next_pc; pend_v ← 0.
- Edge update when stall[0]==Stop:
  - pc_r holds.
  - If br_e: pend_v ← 1, pend_addr ← br_addr. A newer br_e overwrites an older pending redirect.
  - Otherwise pend_v and pend_addr hold.
- Simultaneous br_e and pend_v with PC not stalled: br_e wins; the pending redirect is discarded.
- Combinational outputs:
  - if_to_id_bus = {ce_r, pc_r}.
  - inst_sram_addr = pc_r.
  - fetch_adel = ce_r & (pc_r[1:0] != 0).
  - inst_sram_en = ce_r & ~fetch_adel & (stall[1]==NoStop). Holding en low during an IF/ID stall keeps the SRAM output stable for ID.
- fetch_cnt increments by 1 on each edge where inst_sram_en==1; wraps at 2^32.
- Latency: a branch resolved in ID in cycle t gives inst_sram_addr = br_addr in cycle t+1.
- No delay-slot logic here. The slot instruction is the one already in flight; ID resolves and forwards it.

Test Plan:
- Reset release: rst=0 for 3 cycles, then 1, stall=0.
  - During reset: ce=0, inst_sram_en=0.
  - Cycle 1 after release: pc=32'hBFC0_0000, en=1.
  - Cycle 2: pc=32'hBFC0_0004. fetch_cnt=2 after 2 fetch edges.
- Taken branch: at pc=32'hBFC0_0010 drive br_e=1, br_addr=32'hBFC0_0100 for one cycle → next pc=32'hBFC0_0100, then 32'hBFC0_0104.
- Branch during stall: stall=6'b000011 for 3 cycles with br_e=1/br_addr=32'hBFC0_0200 in the first only.
  - pc holds; en=0 throughout.
  - After release: pc=32'hBFC0_0200, then pend_v=0 and pc continues +4.
- Branch overwrites pending: pend to 32'h200, then br_e to 32'h300 while still stalled → first pc after release = 32'h300. Also, pend_v=1 with a non-stalled br_e to 32'h400 → pc=32'h400.
- Misaligned target: br_addr=32'hBFC0_0102 → fetch_adel=1, inst_sram_en=0, fetch_cnt does not increment; if_to_id_bus={1, 32'hBFC0_0102}.
- Reset mid-operation: rst=0 while pend_v=1 and stall=6'b000001 → all state back to reset values; the first fetch after release is RESET_PC; the pending redirect is lost.
